// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port memory.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [31:0]           if_rdata,
  output logic                  if_ack,
  output logic                  if_stall,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [31:0]           dm_wdata,
  output logic [31:0]           dm_rdata,
  output logic                  dm_ack,
  output logic                  dm_stall,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_dout,
  input  logic [31:0]           mem_din,
  input  logic                  mem_ack,
  output logic                  bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic        owner_dm;
  logic        last_dm;
  logic        grant_dm;
  logic        timed_out;
  logic [31:0] resp_data;

  // On a tie the port that was not served last wins.
  assign grant_dm  = dm_req & (~if_req | ~last_dm);
  assign resp_data = timed_out ? 32'hDEADBEEF : (mem_we ? mem_dout : mem_din);
  assign if_stall  = if_req & ~if_ack;
  assign dm_stall  = dm_req & ~dm_ack;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] tcnt;

  assign timed_out = (state == BUSY) & ~mem_ack & (tcnt == 8'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt    <= '0;
      bus_err <= 1'b0;
    end else begin
      if (state != BUSY) tcnt <= '0;
      else if (!mem_ack) tcnt <= tcnt + 8'd1;
      if (timed_out) bus_err <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
  assign bus_err   = 1'b0;
`endif

  // NOTE: every register here uses <= so all updates take the pre-edge values,
  // independent of statement order inside the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner_dm <= 1'b0;
      last_dm  <= 1'b0;
      mem_cs   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_dout <= '0;
      if_ack   <= 1'b0;
      dm_ack   <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            owner_dm <= grant_dm;
            mem_we   <= grant_dm & dm_we;
            mem_addr <= grant_dm ? dm_addr : if_addr;
            mem_dout <= grant_dm ? dm_wdata : 32'h0;
            mem_cs   <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // Writes echo their own data back as rdata.
          if (mem_ack || timed_out) begin
            mem_cs <= 1'b0;
            state  <= RESP;
            if (owner_dm) begin
              dm_rdata <= resp_data;
              dm_ack   <= 1'b1;
            end else begin
              if_rdata <= resp_data;
              if_ack   <= 1'b1;
            end
          end
        end
        RESP: begin
          if_ack  <= 1'b0;
          dm_ack  <= 1'b0;
          last_dm <= owner_dm;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: requester and memory models driven per cycle,
// expected completions kept in a scoreboard queue in grant order.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, dm_req, dm_we, mem_ack;
  logic [AW-1:0] if_addr, dm_addr;
  logic [31:0]   dm_wdata, mem_din;
  logic [31:0]   if_rdata, dm_rdata, mem_dout;
  logic [AW-1:0] mem_addr;
  logic          if_ack, if_stall, dm_ack, dm_stall, mem_cs, mem_we, bus_err;

  mem_arbiter #(.ADDR_WIDTH(AW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          cs_len;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } job_t;

  exp_t exp_q[$];
  job_t if_jobs[$];
  job_t dm_jobs[$];

  int n_chk = 0;
  int n_pass = 0;
  int ack_delay = 1;
  int bcnt = 0;
  int last_len = 0;
  int t = 0;
  int if_t0 = 0, dm_t0 = 0, if_lat = 0, dm_lat = 0;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h10) ? 32'h8C010004 : ((a * 32'h9E3779B1) ^ 32'h0F0F0000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic exp_push(input logic dm, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int cs_len);
    exp_t e;
    e.dm = dm; e.we = we; e.addr = addr; e.wdata = wdata; e.cs_len = cs_len;
    e.rdata = we ? wdata : mem_model(addr);
    exp_q.push_back(e);
  endtask

  task automatic job(input logic dm, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata);
    job_t j;
    j.we = we; j.addr = addr; j.wdata = wdata;
    if (dm) dm_jobs.push_back(j);
    else    if_jobs.push_back(j);
  endtask

  // One clock: observe the cycle just started, then drive requesters and memory.
  task automatic tick();
    exp_t e;
    job_t j;
    @(posedge clk); #1; t++;
    if (mem_cs) bcnt++;
    else if (bcnt != 0) begin last_len = bcnt; bcnt = 0; end

    if (mem_cs && exp_q.size() != 0) begin
      e = exp_q[0];
      chk("busy_mem_we", mem_we, e.we);
      chk("busy_mem_addr", mem_addr, e.addr);
      if (e.we) chk("busy_mem_dout", mem_dout, e.wdata);
      chk("busy_if_stall", if_stall, if_req);
      chk("busy_dm_stall", dm_stall, dm_req);
    end

    if (if_ack || dm_ack) begin
      chk("ack_expected", exp_q.size() != 0, 1);
      chk("ack_onehot", if_ack & dm_ack, 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ack_port_dm", dm_ack, e.dm);
        chk("ack_rdata", e.dm ? dm_rdata : if_rdata, e.rdata);
        chk("ack_cs_len", last_len, e.cs_len);
        chk("ack_owner_stall", e.dm ? dm_stall : if_stall, 0);
      end
    end

    if (if_ack) begin if_req = 1'b0; if_lat = t - if_t0; end
    if (dm_ack) begin dm_req = 1'b0; dm_lat = t - dm_t0; end
    if (!if_req && if_jobs.size() != 0) begin
      j = if_jobs.pop_front();
      if_req = 1'b1; if_addr = j.addr; if_t0 = t;
    end
    if (!dm_req && dm_jobs.size() != 0) begin
      j = dm_jobs.pop_front();
      dm_req = 1'b1; dm_we = j.we; dm_addr = j.addr; dm_wdata = j.wdata; dm_t0 = t;
    end

    if (mem_cs && ack_delay != 0 && bcnt == ack_delay) begin
      mem_ack = 1'b1;
      mem_din = mem_model(mem_addr);
    end else begin
      mem_ack = 1'b0;
      mem_din = $urandom;
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && if_jobs.size() == 0 && dm_jobs.size() == 0 && !if_req && !dm_req)
        break;
      tick();
    end
    chk(tag, exp_q.size() == 0 && !if_req && !dm_req, 1);
  endtask

  initial begin
    rst = 1'b1;
    if_req = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_din = '0;
    #2;
    chk("rst_mem_cs", mem_cs, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_acks", {if_ack, dm_ack}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_stalls", {if_stall, dm_stall}, 0);
    #10 rst = 1'b0;

    // IF read, immediate memory ack
    ack_delay = 1;
    job(0, 0, 32'h10, 0);
    exp_push(0, 0, 32'h10, 0, 1);
    wait_done("t1_done", 20);
    chk("t1_if_latency", if_lat, 2);

    // DM write with a 3-cycle memory
    ack_delay = 3;
    job(1, 1, 32'h40, 32'h12345678);
    exp_push(1, 1, 32'h40, 32'h12345678, 3);
    wait_done("t2_done", 20);
    chk("t2_dm_latency", dm_lat, 4);
    chk("t2_if_rdata_held", if_rdata, 32'h8C010004);

    // DM address changes mid-access; latched address must be used
    job(1, 0, 32'h40, 0);
    exp_push(1, 0, 32'h40, 0, 3);
    tick(); tick();
    dm_addr = 32'h80;
    wait_done("t3_done", 20);
    chk("t3_dm_wdata_held_rdata", dm_rdata, mem_model(32'h40));

    // Reset in the middle of a never-acked access
    ack_delay = 0;
    job(1, 0, 32'h44, 0);
    exp_push(1, 0, 32'h44, 0, 0);
    repeat (4) tick();
    chk("t4_busy_before_rst", mem_cs, 1);
    rst = 1'b1;
    #1;
    chk("t4_rst_mem_cs", mem_cs, 0);
    chk("t4_rst_no_ack", {if_ack, dm_ack}, 0);
    exp_q.delete();
    dm_req = 1'b0; mem_ack = 1'b0;
    #2 rst = 1'b0;
    repeat (4) tick();
    chk("t4_idle_mem_cs", mem_cs, 0);
    chk("t4_bus_err", bus_err, 0);

    // Simultaneous requests held continuously: DM, IF, DM, IF
    ack_delay = 1;
    job(1, 0, 32'h100, 0);
    job(1, 1, 32'h104, 32'hCAFE0001);
    job(0, 0, 32'h200, 0);
    job(0, 0, 32'h204, 0);
    exp_push(1, 0, 32'h100, 0, 1);
    exp_push(0, 0, 32'h200, 0, 1);
    exp_push(1, 1, 32'h104, 32'hCAFE0001, 1);
    exp_push(0, 0, 32'h204, 0, 1);
    wait_done("t5_done", 40);
    chk("t5_dm_wait", dm_lat, 6);
    chk("t5_if_wait", if_lat, 6);

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: watchdog completes the access with an error
    ack_delay = 0;
    job(0, 0, 32'h20, 0);
    exp_push(0, 0, 32'h20, 0, TO);
    exp_q[0].rdata = 32'hDEADBEEF;
    wait_done("t6_timeout_done", 40);
    chk("t6_bus_err_set", bus_err, 1);
    ack_delay = 1;
    job(0, 0, 32'h24, 0);
    exp_push(0, 0, 32'h24, 0, 1);
    wait_done("t6_good_done", 20);
    chk("t6_bus_err_sticky", bus_err, 1);
`else
    // Without the watchdog a silent memory keeps the arbiter busy
    ack_delay = 0;
    job(0, 0, 32'h20, 0);
    repeat (30) tick();
    chk("t6_still_busy", mem_cs, 1);
    chk("t6_no_bus_err", bus_err, 0);
    chk("t6_if_stall", if_stall, 1);
    rst = 1'b1;
    #2;
    if_req = 1'b0;
    rst = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
